// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: one WIDTH-bit payload, valid/ready handshake, synchronous flush, saturating stall counter.
// Latency 1 cycle; `PIPE_STAGE_SKID_EN adds a skid register so in_ready depends only on state.
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             r_main_vld;
    logic [WIDTH-1:0] r_main_dat;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_acc;
    logic             w_cons;

    assign w_acc     = in_valid && in_ready;
    assign w_cons    = r_main_vld && out_ready;
    assign out_valid = r_main_vld;
    assign out_data  = r_main_dat;
    assign stall_cnt = r_stall_cnt;

    // Counts flush cycles too; only reset clears it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (r_main_vld && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic             r_skid_vld;
    logic [WIDTH-1:0] r_skid_dat;

    assign in_ready  = !r_skid_vld;
    assign occupancy = {1'b0, r_main_vld} + {1'b0, r_skid_vld};

    // Skid is only ever filled behind a valid main word, so FIFO order is main then skid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_main_vld <= 1'b0;
            r_main_dat <= RESET_VAL;
            r_skid_vld <= 1'b0;
            r_skid_dat <= RESET_VAL;
        end else if (flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
            if (w_cons) begin
                r_main_dat <= r_skid_dat;
                r_skid_vld <= 1'b0;
            end
        end else if (r_main_vld && !out_ready) begin
            if (w_acc) begin
                r_skid_vld <= 1'b1;
                r_skid_dat <= in_data;
            end
        end else if (w_acc) begin
            r_main_vld <= 1'b1;
            r_main_dat <= in_data;
        end else if (w_cons) begin
            r_main_vld <= 1'b0;
        end
    end
`else
    assign in_ready  = !r_main_vld || out_ready;
    assign occupancy = {1'b0, r_main_vld};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_main_vld <= 1'b0;
            r_main_dat <= RESET_VAL;
        end else if (flush) begin
            r_main_vld <= 1'b0;
        end else if (w_acc) begin
            r_main_vld <= 1'b1;
            r_main_dat <= in_data;
        end else if (w_cons) begin
            r_main_vld <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: cycle model + scoreboard queue feeding a negedge monitor, plus directed checks.
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic        in_ready2, out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  occupancy2;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .CNT_W(16), .RESET_VAL(32'hA5A5A5A5)) dut (
        .CLK(clk), .RST(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt));

    pipe_stage_reg #(.WIDTH(32), .CNT_W(2), .RESET_VAL(32'hA5A5A5A5)) dut_sat (
        .CLK(clk), .RST(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words held, expected delivery queue, stall counters.
    int          m_cnt = 0;
    int unsigned m_st = 0;
    int unsigned m_st2 = 0;
    logic [31:0] sb[$];

    function automatic bit model_rdy();
        return SKID ? (m_cnt < 2) : (m_cnt == 0 || out_ready);
    endfunction

    always @(posedge clk) begin
        bit cons, acc;
        cons = (m_cnt > 0) && out_ready;
        acc  = in_valid && model_rdy();
        if (rst) begin
            m_cnt = 0; m_st = 0; m_st2 = 0;
            sb.delete();
        end else begin
            if (m_cnt > 0 && !out_ready) begin
                if (m_st < 65535) m_st++;
                if (m_st2 < 3) m_st2++;
            end
            if (flush) begin
                m_cnt = 0;
                sb.delete();
            end else begin
                if (acc) sb.push_back(in_data);
                m_cnt = m_cnt - int'(cons) + int'(acc);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 64'(out_valid), 64'(m_cnt > 0));
            chk("occupancy", 64'(occupancy), 64'(m_cnt));
            chk("in_ready", 64'(in_ready), 64'(model_rdy()));
            chk("stall_cnt", 64'(stall_cnt), 64'(m_st));
            chk("stall_cnt_w2", 64'(stall_cnt2), 64'(m_st2));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("out_data", 64'(out_data), 64'(sb[0]));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic r, input logic f, input logic v, input logic [31:0] d, input logic ordy);
        rst = r; flush = f; in_valid = v; in_data = d; out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'hA5A5A5A5);
        chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
        chk({tag, "_occ"}, 64'(occupancy), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] stream [3] = '{32'h11, 32'h22, 32'h33};

        // Reset with a word presented upstream
        drive(1, 0, 1, 32'h1234, 0);
        step(); step();
        chk_reset_state("reset");
        drive(0, 0, 0, 0, 1);
        mon_en = 1'b1;

        // Streaming, one word per cycle
        foreach (stream[i]) begin
            drive(0, 0, 1, stream[i], 1);
            step();
            chk("stream_data", 64'(out_data), 64'(stream[i]));
            chk("stream_valid", 64'(out_valid), 64'd1);
        end
        drive(0, 0, 0, 0, 1);
        step();
        chk("stream_stall", 64'(stall_cnt), 64'd0);

        // Backpressure; skid build also captures 0xCAFE behind it
        drive(0, 0, 1, 32'hDEADBEEF, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, SKID && i == 0, 32'hCAFE, 0);
            step();
            chk("bp_hold", 64'(out_data), 64'hDEADBEEF);
            if (SKID && i == 0) begin
                chk("bp_occ2", 64'(occupancy), 64'd2);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
            end
        end
        chk("bp_stall", 64'(stall_cnt), 64'd3);
        chk("bp_stall_w2", 64'(stall_cnt2), 64'd3);
        drive(0, 0, 0, 0, 1);
        step(); step();

        // Flush while holding 0x55 with 0x66 offered
        drive(0, 0, 1, 32'h55, 0);
        step();
        drive(0, 1, 1, 32'h66, 0);
        step();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_data_kept", 64'(out_data), 64'h55);
        drive(0, 0, 0, 0, 1);
        step();
        chk("flush_after", 64'(out_valid), 64'd0);

        // Reset while full, then a fresh word
        drive(0, 0, 1, 32'h101, 0);
        step();
        drive(0, 0, 1, 32'h102, 0);
        step();
        drive(1, 0, 1, 32'h103, 1);
        step();
        chk_reset_state("rst_mid");
        drive(0, 0, 1, 32'h77, 1);
        step();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_data", 64'(out_data), 64'h77);
        drive(0, 0, 0, 0, 1);
        step();

        // Saturation of the 2-bit counter
        drive(0, 0, 1, 32'h88, 0);
        step();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        chk("sat_w16", 64'(stall_cnt), 64'd5);
        chk("sat_w2", 64'(stall_cnt2), 64'd3);
        step();
        chk("sat_w2_hold", 64'(stall_cnt2), 64'd3);
        drive(0, 0, 0, 0, 1);
        step(); step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
